// File: rtl/compare_seq.sv
// Bit-serial 8-bit magnitude comparator: four nibbles are strobed in from
// synchronized push-buttons, then compared LSB-first over eight cycles.
module compare_seq #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb1,
  input  logic       pb2,
  input  logic       pb3,
  input  logic       pb4,
  input  logic [3:0] y,
  output logic       l,
  output logic       g,
  output logic       e,
  output logic       valid,
  output logic       busy,
  output logic [1:0] dbg_state,
  output logic [3:0] dbg_mask,
  output logic [2:0] dbg_idx,
  output logic [7:0] dbg_a,
  output logic [7:0] dbg_b
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: there is no valid/ready pair here; a load strobe is a
  // one-cycle pulse that is either consumed (IDLE/DONE) or dropped (RUN).

  logic [3:0] pb_raw;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_d [SYNC_STAGES];
  logic [3:0] edge_q, edge_d;
  logic [3:0] strobe;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] mask_q, mask_d;
  logic [2:0] idx_q, idx_d;
  logic       lt_q, lt_d;
  logic       gt_q, gt_d;
  logic       eq_q, eq_d;
  logic       l_q, l_d;
  logic       g_q, g_d;
  logic       e_q, e_d;
  logic       valid_q, valid_d;

  logic [7:0] a_ld;
  logic [7:0] b_ld;
  logic [3:0] mask_ld;
  logic       a_bit;
  logic       b_bit;
  logic       lt_n;
  logic       gt_n;
  logic       eq_n;

  assign pb_raw = {pb4, pb3, pb2, pb1};

  always_comb begin
    sync_d[0] = pb_raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    edge_d = sync_q[SYNC_STAGES-1];
  end

  assign strobe = sync_q[SYNC_STAGES-1] & ~edge_q;

  // Candidate operand/mask values if this cycle's strobes are accepted.
  always_comb begin
    a_ld    = a_q;
    b_ld    = b_q;
    mask_ld = mask_q | strobe;
    if (strobe[0]) a_ld[3:0] = y;
    if (strobe[1]) a_ld[7:4] = y;
    if (strobe[2]) b_ld[3:0] = y;
    if (strobe[3]) b_ld[7:4] = y;
  end

  // One serial step; a later (higher) differing bit overrides earlier ones.
  always_comb begin
    a_bit = a_q[idx_q];
    b_bit = b_q[idx_q];
    lt_n  = lt_q;
    gt_n  = gt_q;
    eq_n  = eq_q;
    if (a_bit && !b_bit) begin
      gt_n = 1'b1;
      lt_n = 1'b0;
      eq_n = 1'b0;
    end else if (!a_bit && b_bit) begin
      lt_n = 1'b1;
      gt_n = 1'b0;
      eq_n = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    l_d     = l_q;
    g_d     = g_q;
    e_d     = e_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (mask_q == 4'b1111) begin
          // Strobes landing on this edge are intentionally dropped.
          state_d = S_RUN;
          mask_d  = 4'b0000;
          idx_d   = 3'd0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
        end else begin
          a_d    = a_ld;
          b_d    = b_ld;
          mask_d = mask_ld;
        end
      end
      S_RUN: begin
        lt_d  = lt_n;
        gt_d  = gt_n;
        eq_d  = eq_n;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          l_d     = lt_n;
          g_d     = gt_n;
          e_d     = eq_n;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (|strobe) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          a_d     = a_ld;
          b_d     = b_ld;
          mask_d  = mask_ld;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 4'b0000;
      end
      edge_q  <= 4'b0000;
      state_q <= S_IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      mask_q  <= 4'b0000;
      idx_q   <= 3'd0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      l_q     <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      edge_q  <= edge_d;
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      l_q     <= l_d;
      g_q     <= g_d;
      e_q     <= e_d;
      valid_q <= valid_d;
    end
  end

  assign l         = l_q;
  assign g         = g_q;
  assign e         = e_q;
  assign valid     = valid_q;
  assign busy      = (state_q == S_RUN);
  assign dbg_state = state_q;
  assign dbg_mask  = mask_q;
  assign dbg_idx   = idx_q;
  assign dbg_a     = a_q;
  assign dbg_b     = b_q;

endmodule

// File: tb/tb_compare_seq.sv
// Directed bench for compare_seq: nibble loading, serial compare timing,
// strobe rejection during RUN, simultaneous loads and asynchronous reset.
module tb_compare_seq;

  logic       clk;
  logic       rst;
  logic [3:0] pb_vec;
  logic [3:0] y;
  logic       l, g, e, valid, busy;
  logic [1:0] dbg_state;
  logic [3:0] dbg_mask;
  logic [2:0] dbg_idx;
  logic [7:0] dbg_a, dbg_b;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] prev_lge;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  compare_seq #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .pb1(pb_vec[0]), .pb2(pb_vec[1]), .pb3(pb_vec[2]), .pb4(pb_vec[3]),
    .y(y), .l(l), .g(g), .e(e), .valid(valid), .busy(busy),
    .dbg_state(dbg_state), .dbg_mask(dbg_mask), .dbg_idx(dbg_idx),
    .dbg_a(dbg_a), .dbg_b(dbg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Hold a button for three edges: the nibble is written on the third.
  task automatic press(input int n, input logic [3:0] v);
    y         = v;
    pb_vec[n] = 1'b1;
    repeat (3) tick();
    pb_vec[n] = 1'b0;
  endtask

  task automatic load4(input logic [7:0] a, input logic [7:0] b);
    press(0, a[3:0]);
    chk("valid_low_after_first_nibble", valid, 1'b0);
    chk("lge_held_in_idle", {l, g, e}, prev_lge);
    press(1, a[7:4]);
    press(2, b[3:0]);
    press(3, b[7:4]);
    chk("mask_full", dbg_mask, 4'b1111);
    chk("operand_a", dbg_a, a);
    chk("operand_b", dbg_b, b);
  endtask

  task automatic run_and_check(input string tag, input logic [2:0] lge);
    tick();
    chk({tag, "_busy_on_run"}, {busy, dbg_state, dbg_mask}, {1'b1, ST_RUN, 4'b0000});
    repeat (7) tick();
    chk({tag, "_not_done_at_8"}, {valid, busy}, 2'b01);
    tick();
    chk({tag, "_done_at_9"}, {valid, busy, dbg_state}, {1'b1, 1'b0, ST_DONE});
    chk({tag, "_lge"}, {l, g, e}, lge);
    prev_lge = lge;
  endtask

  initial begin
    rst      = 1'b1;
    pb_vec   = 4'b0000;
    y        = 4'h0;
    prev_lge = 3'b000;
    repeat (3) tick();
    chk("reset_outputs", {l, g, e, valid, busy}, 5'b00000);
    chk("reset_state", {dbg_state, dbg_mask, dbg_idx}, 9'd0);
    chk("reset_operands", {dbg_a, dbg_b}, 16'h0000);
    rst = 1'b0;
    tick();

    load4(8'h5A, 8'h5A);
    run_and_check("eq_5a", 3'b001);
    load4(8'h80, 8'h7F);
    run_and_check("gt_80_7f", 3'b010);
    load4(8'h01, 8'h02);
    run_and_check("lt_01_02", 3'b100);
    load4(8'h7F, 8'hFE);
    run_and_check("lt_7f_fe", 3'b100);

    // Button pressed while RUN is in progress must be dropped.
    load4(8'h10, 8'h20);
    repeat (3) tick();
    chk("run_before_press", dbg_state, ST_RUN);
    press(0, 4'hF);
    chk("run_press_ignored_a", dbg_a, 8'h10);
    chk("run_press_ignored_mask", {dbg_state, dbg_mask}, {ST_RUN, 4'b0000});
    repeat (3) tick();
    chk("run_press_done", {valid, l, g, e}, 4'b1100);
    prev_lge = 3'b100;
    repeat (10) tick();
    chk("no_restart", {dbg_state, busy, valid, dbg_a}, {ST_DONE, 1'b0, 1'b1, 8'h10});

    // All four buttons together, held well past the compare.
    y      = 4'h3;
    pb_vec = 4'b1111;
    repeat (3) tick();
    chk("all4_operands", {dbg_a, dbg_b, dbg_mask}, {8'h33, 8'h33, 4'b1111});
    chk("all4_valid_drop", {valid, dbg_state}, {1'b0, ST_IDLE});
    run_and_check("all4", 3'b001);
    repeat (12) tick();
    chk("held_no_restrobe", {dbg_state, valid, dbg_mask, e}, {ST_DONE, 1'b1, 4'b0000, 1'b1});
    pb_vec = 4'b0000;
    repeat (3) tick();

    // Single nibble after DONE: back to IDLE and stays there.
    press(0, 4'h4);
    chk("single_pb1", {valid, busy, dbg_state, dbg_mask}, {1'b0, 1'b0, ST_IDLE, 4'b0001});
    chk("single_pb1_lge_held", {l, g, e}, 3'b001);
    repeat (15) tick();
    chk("single_pb1_wait", {busy, dbg_state, dbg_mask}, {1'b0, ST_IDLE, 4'b0001});
    press(1, 4'h2);
    press(2, 4'h4);
    press(3, 4'h2);
    chk("partial_reload_a_b", {dbg_a, dbg_b}, {8'h24, 8'h24});
    run_and_check("reload_24", 3'b001);

    // Asynchronous reset in the middle of RUN.
    load4(8'hC3, 8'h3C);
    repeat (5) tick();
    chk("mid_run_idx4", {busy, dbg_idx}, {1'b1, 3'd4});
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {l, g, e, valid, busy}, 5'b00000);
    chk("async_reset_state", {dbg_state, dbg_mask, dbg_idx, dbg_a, dbg_b}, 25'd0);
    prev_lge = 3'b000;
    tick();
    // Button held through reset release gives exactly one strobe.
    y         = 4'h0;
    pb_vec[0] = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("held_through_reset", {dbg_mask, dbg_state}, {4'b0001, ST_IDLE});
    pb_vec[0] = 1'b0;
    repeat (2) tick();
    press(1, 4'h0);
    press(2, 4'h1);
    press(3, 4'h0);
    chk("post_reset_operands", {dbg_a, dbg_b, dbg_mask}, {8'h00, 8'h01, 4'b1111});
    run_and_check("post_reset_lt", 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
